divisor_sequencial: RTL

Parametrised sequential restoring divider: one quotient bit per clock, over a configurable operand width, with signed/unsigned mode and divide-by-zero detection. It supersedes the chain of combinational 4-bit division stages in the datapath. A start/busy/done handshake lets the control FSM launch a division and collect the quotient and remainder.

---
 rtl/divisor_pkg.sv | 25 ++
 rtl/passo_divisao.sv | 22 ++
 rtl/divisor_sequencial.sv | 132 +++++++++++++
 3 files changed

// File: rtl/divisor_pkg.sv
// Shared types and helpers for the sequential restoring divider:
// FSM state encoding, legal operand widths and sign conditioning.
package divisor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Bits needed to hold the step counter (WIDTH-1 down to 0).
  function automatic int count_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  // Two's-complement negate when neg is set; callers resize to their WIDTH.
  function automatic logic [WIDTH_MAX-1:0] cond_neg(input logic [WIDTH_MAX-1:0] v,
                                                    input logic                 neg);
    return neg ? (~v + WIDTH_MAX'(1)) : v;
  endfunction

endpackage

// File: rtl/passo_divisao.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference only when it did not borrow.
module passo_divisao #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] partial;
  logic [WIDTH+1:0] diff;

  assign partial = {rem_in, bit_in};
  assign diff    = partial - {2'b00, divisor};
  // The top bit of the widened difference is the borrow.
  assign q_bit   = ~diff[WIDTH+1];
  assign rem_out = q_bit ? diff[WIDTH:0] : partial[WIDTH:0];

endmodule

// File: rtl/divisor_sequencial.sv
// Sequential restoring divider: one quotient bit per clock, signed or unsigned,
// with divide-by-zero detection and a start/busy/done handshake.
module divisor_sequencial
  import divisor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             com_sinal,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quociente,
  output logic [WIDTH-1:0] resto,
  output logic             div_zero
);

  localparam int CW = count_w(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("divisor_sequencial: WIDTH must be within 2..32");
  end

  state_t                state;
  state_t                state_nx;
  logic [CW-1:0]         count;
  logic [WIDTH-1:0]      dvd;
  logic [WIDTH-1:0]      dsr_mag;
  logic [WIDTH:0]        rem;
  logic                  sign_q;
  logic                  sign_r;
  logic                  zero_pend;

  logic signed [WIDTH-1:0] dividendo_s;
  logic signed [WIDTH-1:0] divisor_s;
  logic                    neg_a;
  logic                    neg_b;

  logic [WIDTH:0]        rem_step;
  logic                  q_bit;

  assign dividendo_s = $signed(dividendo);
  assign divisor_s   = $signed(divisor);
  assign neg_a       = com_sinal && (dividendo_s < 0);
  assign neg_b       = com_sinal && (divisor_s < 0);

  passo_divisao #(
    .WIDTH (WIDTH)
  ) u_passo (
    .rem_in  (rem),
    .bit_in  (dvd[WIDTH-1]),
    .divisor (dsr_mag),
    .rem_out (rem_step),
    .q_bit   (q_bit)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (divisor == '0) ? DONE : RUN;
      RUN:     if (count == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      dvd       <= '0;
      dsr_mag   <= '0;
      rem       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      zero_pend <= 1'b0;
      quociente <= '0;
      resto     <= '0;
      div_zero  <= 1'b0;
    end else begin
      state <= state_nx;
      // busy stays high through the cycle in which done is presented.
      busy  <= (state_nx != IDLE) || (state == DONE);
      done  <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            rem   <= '0;
            count <= CW'(WIDTH - 1);
            if (divisor == '0) begin
              zero_pend <= 1'b1;
              dvd       <= dividendo;
              dsr_mag   <= '0;
              sign_q    <= 1'b0;
              sign_r    <= 1'b0;
            end else begin
              zero_pend <= 1'b0;
              dvd       <= WIDTH'(cond_neg(WIDTH_MAX'(dividendo), neg_a));
              dsr_mag   <= WIDTH'(cond_neg(WIDTH_MAX'(divisor), neg_b));
              sign_q    <= neg_a ^ neg_b;
              sign_r    <= neg_a;
            end
          end
        end
        RUN: begin
          // Quotient bits shift in from the bottom as dividend bits leave the top.
          rem   <= rem_step;
          dvd   <= {dvd[WIDTH-2:0], q_bit};
          count <= count - CW'(1);
        end
        DONE: begin
          if (zero_pend) begin
            quociente <= '1;
            resto     <= dvd;
            div_zero  <= 1'b1;
          end else begin
            quociente <= WIDTH'(cond_neg(WIDTH_MAX'(dvd), sign_q));
            resto     <= WIDTH'(cond_neg(WIDTH_MAX'(rem[WIDTH-1:0]), sign_r));
            div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
